rf_wb_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline writeback stage (requester A) and the long-latency execution units, mul/div and misaligned-load sequencer (requester B). B results are buffered in a small FIFO and drained into idle port cycles. A bounded-starvation rule stalls writeback when B has waited too long. The block also reports pending-write hazards on the decode read addresses, so the hazard unit can stall dependent instructions. It sits between the WB stage and `register_file`, and drives that block's `reg_write/rd_addr/rd_data`.

---
 rtl/rv_pkg.sv | 16 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/rf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Purpose: shared widths and the writeback request record for the RF write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN, REG_ADDR_W, wb_req_t {rd, data}.
package rv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Purpose: small circular buffer of wb_req_t entries holding long-latency results.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full/empty come from current occupancy only; push when full and pop when empty are ignored.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, full, empty, head,
//        ent_vld/ent_rd (per-slot occupancy and destination, for hazard compares).
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  wb_req_t                               push_dat,
    input  logic                                  pop,
    output logic                                  full,
    output logic                                  empty,
    output wb_req_t                               head,
    output logic [DEPTH-1:0]                      ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_rd
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slot contents are only meaningful through ent_vld.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // A slot is live when its distance from the read pointer (mod DEPTH) is below occupancy.
    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        ent_vld = '0;
        ent_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, off} < count);
            ent_rd[i]  = mem[i].rd;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the single register-file write port between the WB stage (A) and buffered long-latency results (B).
// Latency: A written 1 cycle after a_valid; B written >= 2 cycles after acceptance, head waits at most STARVE_MAX+2 cycles.
// Backpressure: wb_stall holds WB for one cycle per starvation event; b_ready drops while the B buffer is full.
// Ports: clk, rst (sync, active-high); a_valid/a_rd/a_data -> wb_stall; b_valid/b_rd/b_data <-> b_ready;
//        rs1_addr/rs2_addr -> rs1_pend/rs2_pend (combinational hazards); rf_we/rf_rd/rf_data registered write port.
module rf_wb_arbiter #(
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            wb_stall,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_pend,
    output logic            rs2_pend,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data
);

    import rv_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    wb_req_t                          fifo_head;
    wb_req_t                          b_req;
    wb_req_t                          grant_req;
    logic [DEPTH-1:0]                 ent_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [CNT_W-1:0]                 cnt;
    logic                             starve;
    logic                             grant_a;
    logic                             grant_b;

    assign b_req     = '{rd: b_rd, data: b_data};
    assign b_ready   = !fifo_full && !rst;
    // x0 results complete the handshake but never occupy a slot.
    assign fifo_push = b_valid && b_ready && (b_rd != 5'd0);
    assign fifo_pop  = grant_b;
    assign wb_stall  = starve;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (b_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .ent_vld  (ent_vld),
        .ent_rd   (ent_rd)
    );

    // Priority: starved buffer head, then WB, then buffer head in idle cycles.
    always_comb begin
        starve    = !rst && !fifo_empty && (cnt == CNT_W'(STARVE_MAX));
        grant_b   = !rst && !fifo_empty && (starve || !a_valid);
        grant_a   = !rst && a_valid && !starve;
        grant_req = grant_b ? fifo_head : '{rd: a_rd, data: a_data};
    end

    // Counts consecutive WB wins while something is waiting; any pop or an empty buffer restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            cnt <= '0;
        end else if (grant_a) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= (grant_a || grant_b) && (grant_req.rd != 5'd0);
            if (grant_a || grant_b) begin
                rf_rd   <= grant_req.rd;
                rf_data <= grant_req.data;
            end
        end
    end

    // A source is pending while its write sits in the buffer or in the output register.
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = rf_we && (rf_rd == rs1_addr);
        hit2 = rf_we && (rf_rd == rs2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i] == rs1_addr)) hit1 = 1'b1;
            if (ent_vld[i] && (ent_rd[i] == rs2_addr)) hit2 = 1'b1;
        end
        rs1_pend = (rs1_addr != 5'd0) && hit1;
        rs2_pend = (rs2_addr != 5'd0) && hit2;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose: self-checking bench for rf_wb_arbiter; per-source in-order scoreboards plus cycle-exact directed checks.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: A is held unchanged after a wb_stall; B is held until b_ready.
module tb_rf_wb_arbiter;

    localparam logic [63:0] B_TAG = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [63:0] a_data;
    logic        wb_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [63:0] b_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pend;
    logic        rs2_pend;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_data;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks    = 0;
    int   failures  = 0;
    bit   a_stalled = 1'b0;
    int   a_seq     = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .wb_stall (wb_stall),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data)
    );

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Present a new A result unless the previous one was stalled, in which case re-present it.
    task automatic next_a();
        if (!a_stalled) begin
            a_seq++;
            a_rd   = 5'(1 + a_seq % 15);
            a_data = 64'h0A00_0000_0000_0000 | 64'(a_seq);
        end
        a_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            to_drive();
            a_valid = 1'b0;
            b_valid = 1'b0;
            to_neg();
        end
    endtask

    // Scoreboard: bit 63 of the data tells the source; each source must write in acceptance order.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
            qb.delete();
            a_stalled = 1'b0;
        end else begin
            if (rf_we) begin
                chk_val("sb_rd_nonzero", 64'(rf_rd != 5'd0), 64'd1);
                if (rf_data[63]) begin
                    if (qb.size() == 0) begin
                        chk_val("sb_b_spurious", 64'(qb.size()), 64'd1);
                    end else begin
                        e = qb.pop_front();
                        chk_val("sb_b_rd", 64'(rf_rd), 64'(e.rd));
                        chk_val("sb_b_data", rf_data, e.data);
                    end
                end else begin
                    if (qa.size() == 0) begin
                        chk_val("sb_a_spurious", 64'(qa.size()), 64'd1);
                    end else begin
                        e = qa.pop_front();
                        chk_val("sb_a_rd", 64'(rf_rd), 64'(e.rd));
                        chk_val("sb_a_data", rf_data, e.data);
                    end
                end
            end
            a_stalled = a_valid && wb_stall;
            if (a_valid && !wb_stall && (a_rd != 5'd0)) qa.push_back('{rd: a_rd, data: a_data});
            if (b_valid && b_ready && (b_rd != 5'd0))   qb.push_back('{rd: b_rd, data: b_data});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        logic [4:0]  st_rd;
        logic [63:0] st_data;

        rst = 1'b1; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0; rs1_addr = '0; rs2_addr = '0;
        st_rd = '0; st_data = '0;

        // Reset values
        to_drive();
        to_neg();
        chk_val("rst_wb_stall", 64'(wb_stall), 64'd0);
        chk_val("rst_b_ready", 64'(b_ready), 64'd0);
        to_drive();
        rst = 1'b0;
        to_neg();
        chk_val("post_rst_we", 64'(rf_we), 64'd0);
        chk_val("post_rst_rd", 64'(rf_rd), 64'd0);
        chk_val("post_rst_data", rf_data, 64'd0);
        chk_val("post_rst_b_ready", 64'(b_ready), 64'd1);

        // A path: one-cycle latency
        to_drive();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
        to_neg();
        to_drive();
        a_valid = 1'b0;
        to_neg();
        chk_val("a_we", 64'(rf_we), 64'd1);
        chk_val("a_rd", 64'(rf_rd), 64'd5);
        chk_val("a_data", rf_data, 64'h1234);

        // B path with A idle, plus hazard flags
        to_drive();
        b_valid = 1'b1; b_rd = 5'd9; b_data = B_TAG | 64'hDEAD; rs1_addr = 5'd9; rs2_addr = 5'd0;
        to_neg();
        chk_val("b_ready_idle", 64'(b_ready), 64'd1);
        chk_val("b_pend_t0", 64'(rs1_pend), 64'd0);
        to_drive();
        b_valid = 1'b0;
        to_neg();
        chk_val("b_pend_t1", 64'(rs1_pend), 64'd1);
        chk_val("b_pend_x0", 64'(rs2_pend), 64'd0);
        to_drive();
        to_neg();
        chk_val("b_pend_t2", 64'(rs1_pend), 64'd1);
        chk_val("b_we_t2", 64'(rf_we), 64'd1);
        chk_val("b_rd_t2", 64'(rf_rd), 64'd9);
        to_drive();
        to_neg();
        chk_val("b_pend_t3", 64'(rs1_pend), 64'd0);
        rs1_addr = 5'd0;
        idle(2);

        // Full buffer while A wins every cycle; fifth offer waits for the first (starvation) pop
        for (int k = 0; k < 4; k++) begin
            to_drive();
            next_a();
            b_valid = 1'b1; b_rd = 5'(16 + k); b_data = B_TAG | 64'(k);
            to_neg();
            chk_val("full_push_ready", 64'(b_ready), 64'd1);
        end
        w = -1;
        for (int k = 0; k < 20; k++) begin
            to_drive();
            next_a();
            b_valid = 1'b1; b_rd = 5'd20; b_data = B_TAG | 64'd4;
            to_neg();
            if (b_ready) begin
                w = k;
                break;
            end
        end
        chk_val("full_ready_wait", 64'(w), 64'd6);
        to_drive();
        next_a();
        b_valid = 1'b0;
        to_neg();
        idle(8);

        // Starvation: one B entry against continuous A traffic
        for (int k = 0; k < 13; k++) begin
            to_drive();
            next_a();
            b_valid = (k == 0); b_rd = 5'd21; b_data = B_TAG | 64'h55;
            to_neg();
            chk_val($sformatf("starve_stall_k%0d", k), 64'(wb_stall), 64'(k == 9));
            if (k == 9) begin
                st_rd   = a_rd;
                st_data = a_data;
            end
            if (k == 10) begin
                chk_val("starve_b_we", 64'(rf_we), 64'd1);
                chk_val("starve_b_rd", 64'(rf_rd), 64'd21);
                chk_val("starve_b_data", rf_data, B_TAG | 64'h55);
            end
            if (k == 11) begin
                chk_val("starve_a_we", 64'(rf_we), 64'd1);
                chk_val("starve_a_rd", 64'(rf_rd), 64'(st_rd));
                chk_val("starve_a_data", rf_data, st_data);
            end
        end
        idle(3);

        // x0 writes are consumed without a write and without occupying the buffer
        to_drive();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h77;
        b_valid = 1'b1; b_rd = 5'd0; b_data = B_TAG | 64'h99;
        to_neg();
        chk_val("x0_b_handshake", 64'(b_ready), 64'd1);
        chk_val("x0_no_stall", 64'(wb_stall), 64'd0);
        to_drive();
        a_valid = 1'b0; b_valid = 1'b0;
        to_neg();
        chk_val("x0_we_t1", 64'(rf_we), 64'd0);
        chk_val("x0_fifo_empty", 64'(dut.fifo_empty), 64'd1);
        to_drive();
        to_neg();
        chk_val("x0_we_t2", 64'(rf_we), 64'd0);

        // Reset with two buffered B results discards them
        rs1_addr = 5'd17;
        for (int k = 0; k < 2; k++) begin
            to_drive();
            next_a();
            b_valid = 1'b1; b_rd = 5'(17 + k); b_data = B_TAG | 64'(256 + k);
            to_neg();
        end
        to_drive();
        next_a();
        b_valid = 1'b0;
        to_neg();
        chk_val("pre_rst_pend", 64'(rs1_pend), 64'd1);
        to_drive();
        rst = 1'b1; a_valid = 1'b0;
        to_neg();
        chk_val("mid_rst_b_ready", 64'(b_ready), 64'd0);
        chk_val("mid_rst_stall", 64'(wb_stall), 64'd0);
        to_drive();
        rst = 1'b0;
        to_neg();
        chk_val("mid_rst_we", 64'(rf_we), 64'd0);
        chk_val("mid_rst_rd", 64'(rf_rd), 64'd0);
        chk_val("mid_rst_data", rf_data, 64'd0);
        chk_val("mid_rst_b_ready_after", 64'(b_ready), 64'd1);
        chk_val("mid_rst_pend", 64'(rs1_pend), 64'd0);
        chk_val("mid_rst_fifo_empty", 64'(dut.fifo_empty), 64'd1);
        idle(3);

        chk_val("sb_a_drained", 64'(qa.size()), 64'd0);
        chk_val("sb_b_drained", 64'(qb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
